// File: rtl/sprite_fetcher.sv
// Sprite fetcher: walks lx across the line, fetches chain hits from VRAM and merges them into an 8-slot pixel shifter.
// Optional macro SPRITE_FETCH_COUNT_EN adds a saturating per-line fetch counter output (fetch_count).
module sprite_fetcher #(
    parameter int VRAM_LAT = 1,
    parameter int LINE_END = 168
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    output logic [7:0]  lx,
    output logic        query,
    input  logic [14:0] chain_d,
    input  logic        chain_valid,
    output logic [12:0] vram_addr,
    output logic        vram_re,
    input  logic [7:0]  vram_d,
    input  logic        pixel_advance,
    output logic        stall,
    output logic [1:0]  spr_color,
    output logic        spr_palette,
    output logic        spr_priority,
    output logic        busy
`ifdef SPRITE_FETCH_COUNT_EN
    ,
    output logic [3:0]  fetch_count
`endif
);

    typedef enum logic [2:0] {IDLE, QUERY, ADDR_LO, WAIT_LO, ADDR_HI, WAIT_HI, MERGE} state_t;

    typedef struct packed {
        logic [1:0] color;
        logic       pal;
        logic       pri;
    } slot_t;

    typedef slot_t [7:0] row_t;

    state_t     state, state_d;
    logic [1:0] wcnt;
    row_t       shift_q;
    logic [7:0] tile_q;
    logic [2:0] dy_q;
    logic       xflip_q, pal_q, pri_q;
    logic [7:0] lo_q;
    logic       take_hit, cap_lo, do_merge, do_adv;
    logic       unused_yflip;

    // y-flip is already folded into dy by the chain
    assign unused_yflip = chain_d[2];

    // Earlier-fetched pixels stay put; only transparent slots take the new sprite's opaque pixels.
    function automatic row_t merge_row(input row_t cur, input logic [7:0] lo, input logic [7:0] hi,
                                       input logic xflip, input logic pal, input logic pri);
        row_t       r;
        logic [2:0] b;
        logic [1:0] c;
        r = cur;
        for (int i = 0; i < 8; i++) begin
            b = xflip ? 3'(i) : 3'(7 - i);
            c = {hi[b], lo[b]};
            if (r[i].color == 2'd0 && c != 2'd0) r[i] = '{color: c, pal: pal, pri: pri};
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state;
        query     = 1'b0;
        stall     = 1'b0;
        vram_re   = 1'b0;
        vram_addr = '0;
        take_hit  = 1'b0;
        cap_lo    = 1'b0;
        do_merge  = 1'b0;
        do_adv    = 1'b0;
        case (state)
            IDLE: ;
            QUERY: begin
                query = 1'b1;
                if (chain_valid) begin
                    stall    = 1'b1;
                    take_hit = 1'b1;
                    state_d  = ADDR_LO;
                end else if (pixel_advance) begin
                    do_adv = 1'b1;
                    if (lx == 8'(LINE_END - 1)) state_d = IDLE;
                end
            end
            ADDR_LO: begin
                stall     = 1'b1;
                vram_re   = 1'b1;
                vram_addr = {1'b0, tile_q, dy_q, 1'b0};
                state_d   = WAIT_LO;
            end
            WAIT_LO: begin
                stall = 1'b1;
                if (wcnt == 2'(VRAM_LAT - 1)) begin
                    cap_lo  = 1'b1;
                    state_d = ADDR_HI;
                end
            end
            ADDR_HI: begin
                stall     = 1'b1;
                vram_re   = 1'b1;
                vram_addr = {1'b0, tile_q, dy_q, 1'b1};
                state_d   = (VRAM_LAT == 1) ? MERGE : WAIT_HI;
            end
            WAIT_HI: begin
                stall = 1'b1;
                if (wcnt == 2'(VRAM_LAT - 2)) state_d = MERGE;
            end
            MERGE: begin
                stall    = 1'b1;
                do_merge = 1'b1;
                state_d  = QUERY;
            end
            default: state_d = IDLE;
        endcase
        if (line_start) state_d = QUERY;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            lx      <= '0;
            busy    <= 1'b0;
            shift_q <= '0;
        end else begin
            state <= state_d;
            wcnt  <= (state_d != state) ? 2'd0 : wcnt + 2'd1;
            if (line_start) begin
                lx      <= '0;
                busy    <= 1'b1;
                shift_q <= '0;
            end else if (do_adv) begin
                lx      <= lx + 8'd1;
                shift_q <= row_t'({4'b0, shift_q[7:1]});
                if (lx == 8'(LINE_END - 1)) busy <= 1'b0;
            end else if (do_merge) begin
                // high plane is consumed straight off the bus in the cycle it arrives
                shift_q <= merge_row(shift_q, lo_q, vram_d, xflip_q, pal_q, pri_q);
            end else if (state == IDLE) begin
                shift_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_hit) begin
            dy_q    <= chain_d[14:12];
            tile_q  <= chain_d[11:4];
            xflip_q <= chain_d[1];
            pal_q   <= chain_d[0];
            pri_q   <= chain_d[3];
        end
        if (cap_lo) lo_q <= vram_d;
    end

    assign spr_color    = shift_q[0].color;
    assign spr_palette  = shift_q[0].pal;
    assign spr_priority = shift_q[0].pri;

`ifdef SPRITE_FETCH_COUNT_EN
    logic [3:0] fcnt;

    always_ff @(posedge clk) begin
        if (!rst || line_start) fcnt <= '0;
        else if (do_merge && fcnt != 4'd10) fcnt <= fcnt + 4'd1;
    end

    assign fetch_count = fcnt;
`endif

endmodule

// File: tb/tb_sprite_fetcher.sv
// Bench for sprite_fetcher: chain and VRAM models plus a line-buffer reference of the sprite pixels.
module tb_sprite_fetcher;
    localparam int LAT      = 1;
    localparam int LINE_END = 168;

    logic        clk = 1'b0;
    logic        rst, line_start, query, chain_valid, vram_re, pixel_advance, stall;
    logic        spr_palette, spr_priority, busy;
    logic [7:0]  lx, vram_d;
    logic [14:0] chain_d;
    logic [12:0] vram_addr;
    logic [1:0]  spr_color;
`ifdef SPRITE_FETCH_COUNT_EN
    logic [3:0]  fetch_count;
`endif

    always #5 clk = ~clk;

    sprite_fetcher #(.VRAM_LAT(LAT), .LINE_END(LINE_END)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .lx(lx), .query(query),
        .chain_d(chain_d), .chain_valid(chain_valid), .vram_addr(vram_addr), .vram_re(vram_re),
        .vram_d(vram_d), .pixel_advance(pixel_advance), .stall(stall), .spr_color(spr_color),
        .spr_palette(spr_palette), .spr_priority(spr_priority), .busy(busy)
`ifdef SPRITE_FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int last_stall_len = 0;

    // sprites of the current line and a staging list for the next one
    int         nspr = 0;
    int         n_stage = 0;
    logic [7:0] sx [16];
    logic [7:0] stile [16];
    logic [2:0] sdy [16];
    logic [3:0] sattr [16];
    logic       used [16];
    logic [7:0] gx [16];
    logic [7:0] gtile [16];
    logic [2:0] gdy [16];
    logic [3:0] gattr [16];

    logic [7:0]  mem [8192];
    logic        pv [LAT];
    logic [12:0] pa [LAT];
    logic [7:0]  junk;

    int lb_col [256];
    int lb_pal [256];
    int lb_pri [256];
    int emit [256];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // chain: combinational hit on the first unconsumed sprite at the queried x
    always_comb begin
        chain_valid = 1'b0;
        chain_d     = '0;
        for (int k = 15; k >= 0; k--) begin
            if (query && k < nspr && !used[4'(k)] && sx[4'(k)] == lx) begin
                chain_valid = 1'b1;
                chain_d     = {sdy[4'(k)], stile[4'(k)], sattr[4'(k)]};
            end
        end
    end

    // VRAM: data valid exactly LAT cycles after the strobe, junk otherwise
    always @(posedge clk) begin
        junk  <= 8'($urandom);
        pv[0] <= vram_re;
        pa[0] <= vram_addr;
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end

    always_comb vram_d = pv[LAT-1] ? mem[pa[LAT-1]] : junk;

    task automatic add_spr(input int x, input int tile, input int dy, input int attr);
        gx[4'(n_stage)]    = 8'(x);
        gtile[4'(n_stage)] = 8'(tile);
        gdy[4'(n_stage)]   = 3'(dy);
        gattr[4'(n_stage)] = 4'(attr);
        n_stage++;
    endtask

    function automatic int find_hit(input int x);
        for (int k = 0; k < nspr; k++)
            if (!used[4'(k)] && int'(sx[4'(k)]) == x) return k;
        return -1;
    endfunction

    // reference: place the sprite row into an absolute-x line buffer, first writer wins
    task automatic model_merge(input int k);
        int x, lo, hi, b, c, p;
        int base;
        base = int'(stile[4'(k)]) * 16 + int'(sdy[4'(k)]) * 2;
        x  = int'(sx[4'(k)]);
        lo = int'(mem[13'(base)]);
        hi = int'(mem[13'(base + 1)]);
        for (int i = 0; i < 8; i++) begin
            b = sattr[4'(k)][1] ? i : 7 - i;
            c = ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
            p = x + i;
            if (lb_col[8'(p)] == 0 && c != 0) begin
                lb_col[8'(p)] = c;
                lb_pal[8'(p)] = int'(sattr[4'(k)][0]);
                lb_pri[8'(p)] = int'(sattr[4'(k)][3]);
            end
        end
    endtask

    function automatic int spr_word();
        return int'(spr_color) + 4 * int'(spr_palette) + 8 * int'(spr_priority);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_lx"}, int'(lx), 0);
        check({tag, "_query"}, int'(query), 0);
        check({tag, "_vram_re"}, int'(vram_re), 0);
        check({tag, "_vram_addr"}, int'(vram_addr), 0);
        check({tag, "_stall"}, int'(stall), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_spr"}, spr_word(), 0);
    endtask

    task automatic run_line(input int prob, input int stop_after, input int rst_at_hit);
        int  mlx, left, hits, pend, run, h, ea, exp_re;
        bit  mbusy, done;
        @(negedge clk);
        nspr = n_stage;
        for (int k = 0; k < 16; k++) begin
            sx[4'(k)] = gx[4'(k)]; stile[4'(k)] = gtile[4'(k)];
            sdy[4'(k)] = gdy[4'(k)]; sattr[4'(k)] = gattr[4'(k)];
            used[4'(k)] = 1'b0;
        end
        n_stage = 0;
        for (int p = 0; p < 256; p++) begin
            lb_col[8'(p)] = 0; lb_pal[8'(p)] = 0; lb_pri[8'(p)] = 0; emit[8'(p)] = -1;
        end
        line_start = 1'b1;
        pixel_advance = 1'b0;
        mlx = 0; left = 0; hits = 0; pend = -1; run = 0; ea = 0; mbusy = 1'b1; done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            line_start = 1'b0;
            if (pend >= 0) begin used[4'(pend)] = 1'b1; pend = -1; end
            pixel_advance = ($urandom_range(99) < prob);
            if (stall) run++;
            else begin
                if (run > 0) last_stall_len = run;
                run = 0;
            end
            if (!mbusy) begin
                check("busy_end", int'(busy), 0);
                check("query_end", int'(query), 0);
`ifdef SPRITE_FETCH_COUNT_EN
                check("fetch_count_end", int'(fetch_count), (hits > 10) ? 10 : hits);
`endif
                @(negedge clk);
                check("spr_cleared", spr_word(), 0);
                done = 1'b1;
            end else begin
`ifdef SPRITE_FETCH_COUNT_EN
                if (cyc == 0) check("fetch_count_start", int'(fetch_count), 0);
`endif
                check("busy", int'(busy), 1);
                check("lx", int'(lx), mlx);
                if (left > 0) begin
                    check("stall_fetch", int'(stall), 1);
                    check("query_fetch", int'(query), 0);
                    exp_re = (left == 2*LAT+2 || left == LAT+1) ? 1 : 0;
                    check("vram_re", int'(vram_re), exp_re);
                    if (exp_re == 1)
                        check("vram_addr", int'(vram_addr), ea + ((left == LAT+1) ? 1 : 0));
                    if (rst_at_hit == hits && left == LAT+1) begin
                        rst = 1'b0;
                        @(negedge clk);
                        rst = 1'b1;
                        check_idle_outputs("rst_now");
                        repeat (3) @(negedge clk);
                        check_idle_outputs("rst_later");
`ifdef SPRITE_FETCH_COUNT_EN
                        check("fetch_count_rst", int'(fetch_count), 0);
`endif
                        return;
                    end
                    left--;
                end else begin
                    check("query", int'(query), 1);
                    check("vram_re_q", int'(vram_re), 0);
                    h = find_hit(mlx);
                    check("stall_q", int'(stall), (h >= 0) ? 1 : 0);
                    if (h >= 0) begin
                        pend = h;
                        model_merge(h);
                        ea   = int'(stile[4'(h)]) * 16 + int'(sdy[4'(h)]) * 2;
                        left = 2*LAT + 2;
                        hits++;
                    end else begin
                        check("spr", spr_word(),
                              lb_col[8'(mlx)] + 4 * lb_pal[8'(mlx)] + 8 * lb_pri[8'(mlx)]);
                        if (pixel_advance) begin
                            emit[8'(mlx)] = spr_word();
                            mlx++;
                            if (mlx == LINE_END) mbusy = 1'b0;
                        end
                    end
                end
                if (stop_after > 0 && cyc == stop_after) return;
            end
        end
        if (!done) check("line_timeout", 0, 1);
    endtask

    initial begin
        int e_noflip [8];
        int e_flip [8];
        e_noflip = '{3, 1, 3, 1, 2, 0, 2, 0};
        e_flip   = '{0, 2, 0, 2, 1, 3, 1, 3};
        rst = 1'b0;
        line_start = 1'b0;
        pixel_advance = 1'b0;
        for (int i = 0; i < 8192; i++) mem[13'(i)] = 8'($urandom);
        for (int k = 0; k < 16; k++) used[4'(k)] = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;

        // empty line: never stalls, all transparent
        run_line(100, 0, 0);

        mem[13'h126] = 8'hF0;
        mem[13'h127] = 8'hAA;
        add_spr(8, 'h12, 3, 0);
        run_line(100, 0, 0);
        check("stall_len", last_stall_len, 2*LAT + 3);
        for (int i = 0; i < 8; i++) check("emit_noflip", emit[8'(8+i)] & 3, e_noflip[i]);

        add_spr(8, 'h12, 3, 4'b0010);
        run_line(100, 0, 0);
        for (int i = 0; i < 8; i++) check("emit_xflip", emit[8'(8+i)] & 3, e_flip[i]);

        mem[13'h200] = 8'h0F; mem[13'h201] = 8'h0F;
        mem[13'h210] = 8'hFF; mem[13'h211] = 8'hFF;
        add_spr(8, 'h20, 0, 4'b0000);
        add_spr(8, 'h21, 0, 4'b0001);
        run_line(100, 0, 0);
        for (int i = 0; i < 8; i++) check("emit_overlap", emit[8'(8+i)], (i < 4) ? 7 : 3);

        // reset during the second sprite's high-plane read
        add_spr(0, 'h12, 3, 0);
        add_spr(1, 'h21, 0, 4'b1001);
        run_line(100, 0, 2);
        run_line(70, 0, 0);

        for (int k = 0; k < 12; k++) add_spr(k * 13, $urandom_range(255), k % 8, $urandom_range(15));
        run_line(100, 0, 0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(10);
            for (int k = 0; k < n; k++)
                add_spr($urandom_range(LINE_END + 3), $urandom_range(255), $urandom_range(7),
                        $urandom_range(15));
            run_line($urandom_range(100, 40), (r == 2) ? $urandom_range(150, 30) : 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
